// File: rtl/wash_pkg.sv
// Shared programme codes, programme times, run-state codes and the time lookup
// for the wash front-panel input stage.
package wash_pkg;

   localparam int unsigned MOD_W = 3;
   localparam int unsigned TT_W  = 6;

   localparam logic [MOD_W-1:0] MOD_STD   = 3'd0;
   localparam logic [MOD_W-1:0] MOD_WASH  = 3'd1;
   localparam logic [MOD_W-1:0] MOD_WR    = 3'd2;
   localparam logic [MOD_W-1:0] MOD_RINSE = 3'd3;
   localparam logic [MOD_W-1:0] MOD_RS    = 3'd4;
   localparam logic [MOD_W-1:0] MOD_SPIN  = 3'd5;

   localparam logic [TT_W-1:0] T_STD   = 6'd33;
   localparam logic [TT_W-1:0] T_WASH  = 6'd12;
   localparam logic [TT_W-1:0] T_WR    = 6'd27;
   localparam logic [TT_W-1:0] T_RINSE = 6'd15;
   localparam logic [TT_W-1:0] T_RS    = 6'd21;
   localparam logic [TT_W-1:0] T_SPIN  = 6'd6;

   typedef enum logic [1:0] {
      RS_OFF   = 2'd0,
      RS_IDLE  = 2'd1,
      RS_RUN   = 2'd2,
      RS_PAUSE = 2'd3
   } run_state_e;

   // Programme payload handed to the sequencer together with the mod strobe.
   typedef struct packed {
      logic [MOD_W-1:0] code;
      logic [TT_W-1:0]  tt;
   } prog_t;

   function automatic logic [TT_W-1:0] prog_time(input logic [MOD_W-1:0] code);
      logic [TT_W-1:0] t;
      case (code)
         MOD_WASH:  t = T_WASH;
         MOD_WR:    t = T_WR;
         MOD_RINSE: t = T_RINSE;
         MOD_RS:    t = T_RS;
         MOD_SPIN:  t = T_SPIN;
         default:   t = T_STD;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse when a press (0->1) is accepted.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic ev_o
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          ev_q;
   logic [CW-1:0] cnt_q;

   // Counter tracks consecutive samples that disagree with the accepted level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         ev_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         ev_q    <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
            ev_q    <= sync2_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign ev_o = ev_q;

endmodule

// File: rtl/wash_panel_in.sv
// Front-panel input stage: debounced buttons drive the power/run FSM,
// programme selection and the 1 Hz step tick for the wash sequencer.
module wash_panel_in
   import wash_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 20000,
   parameter int unsigned TICK_DIV  = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_mode,
   input  logic              btn_start,
   input  logic              btn_power,
   input  logic              tt_zero,
   output logic              mod,
   output logic [MOD_W-1:0]  mod1,
   output logic [TT_W-1:0]   Tt1,
   output logic              s,
   output logic              p,
   output logic              ts,
   output logic [1:0]        run_state
);

   localparam int unsigned TW = $clog2(TICK_DIV + 1);

   logic ev_mode;
   logic ev_start;
   logic ev_power;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_mode),
      .ev_o  (ev_mode)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_start),
      .ev_o  (ev_start)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_power (
      .clk   (clk),
      .rst   (rst),
      .btn_i (btn_power),
      .ev_o  (ev_power)
   );

   run_state_e       state_q;
   prog_t            prog_q;
   logic             done_q;
   logic             mod_q;
   logic             pend_q;
   logic             s_q;
   logic             p_q;
   logic             ts_q;
   logic [TW-1:0]    tick_q;
   logic [MOD_W-1:0] mode_next_c;

   always_comb begin
      mode_next_c = (prog_q.code == MOD_SPIN) ? MOD_STD : prog_q.code + MOD_W'(1);
   end

   // Power off outranks everything; within a state start outranks mode.
   // A mode change updates Tt1 now and strobes mod one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RS_OFF;
         prog_q.code <= MOD_STD;
         prog_q.tt   <= T_STD;
         done_q      <= 1'b0;
         mod_q       <= 1'b0;
         pend_q      <= 1'b0;
         s_q         <= 1'b0;
         p_q         <= 1'b0;
         ts_q        <= 1'b0;
         tick_q      <= '0;
      end else begin
         mod_q  <= pend_q;
         pend_q <= 1'b0;
         ts_q   <= 1'b0;
         tick_q <= '0;
         if (ev_power && state_q != RS_OFF) begin
            state_q     <= RS_OFF;
            prog_q.code <= MOD_STD;
            prog_q.tt   <= T_STD;
            done_q      <= 1'b0;
            mod_q       <= 1'b1;
            s_q         <= 1'b0;
            p_q         <= 1'b0;
         end else begin
            unique case (state_q)
               RS_OFF: begin
                  if (ev_power) begin
                     state_q <= RS_IDLE;
                     p_q     <= 1'b1;
                  end
               end
               RS_IDLE: begin
                  if (ev_start) begin
                     if (done_q) begin
                        done_q <= 1'b0;
                        mod_q  <= 1'b1;
                     end else begin
                        state_q <= RS_RUN;
                        s_q     <= 1'b1;
                     end
                  end else if (ev_mode) begin
                     prog_q.code <= mode_next_c;
                     prog_q.tt   <= prog_time(mode_next_c);
                     pend_q      <= 1'b1;
                  end
               end
               RS_RUN: begin
                  if (tt_zero) begin
                     state_q <= RS_IDLE;
                     s_q     <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (ev_start) begin
                     state_q <= RS_PAUSE;
                     s_q     <= 1'b0;
                  end else if (tick_q == TW'(TICK_DIV - 1)) begin
                     ts_q <= 1'b1;
                  end else begin
                     tick_q <= tick_q + TW'(1);
                  end
               end
               RS_PAUSE: begin
                  if (ev_start) begin
                     state_q <= RS_RUN;
                     s_q     <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign mod       = mod_q;
   assign mod1      = prog_q.code;
   assign Tt1       = prog_q.tt;
   assign s         = s_q;
   assign p         = p_q;
   assign ts        = ts_q;
   assign run_state = state_q;

endmodule

// File: tb/tb_wash_panel_in.sv
// Bench for wash_panel_in: directed panel scenarios plus random button traffic,
// every output checked each cycle against a behavioural panel model.
module tb_wash_panel_in;

   localparam int DB = 4;
   localparam int TD = 8;
   localparam int HL = DB + 2;

   logic       clk;
   logic       rst;
   logic       btn_mode;
   logic       btn_start;
   logic       btn_power;
   logic       tt_zero;
   logic       mod;
   logic [2:0] mod1;
   logic [5:0] Tt1;
   logic       s;
   logic       p;
   logic       ts;
   logic [1:0] run_state;

   wash_panel_in #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_start (btn_start),
      .btn_power (btn_power),
      .tt_zero   (tt_zero),
      .mod       (mod),
      .mod1      (mod1),
      .Tt1       (Tt1),
      .s         (s),
      .p         (p),
      .ts        (ts),
      .run_state (run_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   // Behavioural model: programme table, panel state, and per-button sample history.
   int tt_tab [6] = '{33, 12, 27, 15, 21, 6};
   int m_mod1, m_tt1, m_run, m_age;
   bit m_mod, m_s, m_p, m_ts, m_done, m_pend;
   bit m_lvl [3];
   bit m_ev  [3];
   bit hist  [3][HL];

   function automatic void model_reset();
      m_mod1 = 0; m_tt1 = 33; m_run = 0; m_age = 0;
      m_mod = 0; m_s = 0; m_p = 0; m_ts = 0; m_done = 0; m_pend = 0;
      for (int b = 0; b < 3; b++) begin
         m_lvl[b] = 0;
         m_ev[b]  = 0;
         for (int j = 0; j < HL; j++) hist[b][j] = 0;
      end
   endfunction

   function automatic void model_step();
      bit em, es, ep, all_diff;
      int prev_run;
      bit raw [3];
      if (rst) begin
         model_reset();
         return;
      end
      em = m_ev[0]; es = m_ev[1]; ep = m_ev[2];
      prev_run = m_run;
      m_mod  = m_pend;
      m_pend = 0;
      m_ts   = 0;
      if (ep && m_run != 0) begin
         m_run = 0; m_p = 0; m_s = 0; m_mod1 = 0; m_tt1 = 33; m_mod = 1; m_done = 0;
      end else if (m_run == 0) begin
         if (ep) begin m_run = 1; m_p = 1; end
      end else if (m_run == 1) begin
         if (es) begin
            if (m_done) begin m_done = 0; m_mod = 1; end
            else begin m_run = 2; m_s = 1; end
         end else if (em) begin
            m_mod1 = (m_mod1 + 1) % 6;
            m_tt1  = tt_tab[m_mod1];
            m_pend = 1;
         end
      end else if (m_run == 2) begin
         if (tt_zero) begin m_run = 1; m_s = 0; m_done = 1; end
         else if (es) begin m_run = 3; m_s = 0; end
      end else begin
         if (es) begin m_run = 2; m_s = 1; end
      end
      // Tick every TD cycles of uninterrupted running.
      if (m_run == 2 && prev_run == 2) begin
         m_age++;
         m_ts = (m_age % TD) == 0;
      end else begin
         m_age = 0;
      end
      // A press is accepted once the last DB synchronised samples all disagree.
      raw[0] = btn_mode; raw[1] = btn_start; raw[2] = btn_power;
      for (int b = 0; b < 3; b++) begin
         for (int j = HL - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
         hist[b][0] = raw[b];
         all_diff = 1;
         for (int j = 2; j < HL; j++) if (hist[b][j] == m_lvl[b]) all_diff = 0;
         m_ev[b] = 0;
         if (all_diff) begin
            m_lvl[b] = ~m_lvl[b];
            m_ev[b]  = m_lvl[b];
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("mod",       32'(mod),       32'(m_mod));
      check("mod1",      32'(mod1),      32'(m_mod1));
      check("Tt1",       32'(Tt1),       32'(m_tt1));
      check("s",         32'(s),         32'(m_s));
      check("p",         32'(p),         32'(m_p));
      check("ts",        32'(ts),        32'(m_ts));
      check("run_state", 32'(run_state), 32'(m_run));
   endtask

   task automatic press(input int b, input int hi, input int lo);
      if (b == 0) btn_mode = 1'b1; else if (b == 1) btn_start = 1'b1; else btn_power = 1'b1;
      repeat (hi) step();
      btn_mode = 1'b0; btn_start = 1'b0; btn_power = 1'b0;
      repeat (lo) step();
   endtask

   int  hold [3];
   bit  rlvl [3];

   initial begin
      rst = 1'b1; btn_mode = 1'b0; btn_start = 1'b0; btn_power = 1'b0; tt_zero = 1'b0;
      model_reset();
      repeat (2) step();
      rst = 1'b0;
      step();
      press(2, 10, 10);                             // power on
      for (int i = 0; i < 6; i++) press(0, 8, 8);   // mode cycling through all programmes
      press(1, 8, 30);                              // start, several ticks
      press(1, 8, 12);                              // pause
      press(1, 8, 20);                              // resume
      press(0, 8, 8);                               // mode while running is ignored
      btn_mode = 1'b1; repeat (3) step(); btn_mode = 1'b0; repeat (10) step();
      tt_zero = 1'b1; step(); tt_zero = 1'b0; repeat (4) step();
      press(1, 8, 8);                               // reload only
      press(1, 8, 20);                              // runs again
      btn_power = 1'b1; btn_start = 1'b1;           // power beats start
      repeat (8) step();
      btn_power = 1'b0; btn_start = 1'b0;
      repeat (12) step();
      press(2, 8, 8);
      press(1, 8, 8);
      rst = 1'b1; step(); rst = 1'b0; repeat (4) step();

      for (int b = 0; b < 3; b++) begin hold[b] = 0; rlvl[b] = 0; end
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (hold[b] == 0) begin
               rlvl[b] = ~rlvl[b];
               if (rlvl[b]) hold[b] = int'($urandom_range(1, 12));
               else if (b == 2) hold[b] = int'($urandom_range(40, 200));
               else hold[b] = int'($urandom_range(2, 30));
            end
            hold[b]--;
         end
         btn_mode  = rlvl[0];
         btn_start = rlvl[1];
         btn_power = rlvl[2];
         tt_zero   = ($urandom_range(0, 40) == 0);
         rst       = ($urandom_range(0, 1500) == 0);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
